// File: rtl/calc_pkg.sv
// Shared types and sizing helpers for the hex-calculator ALU sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } calc_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int unsigned CALC_WIDTH = 32;

  // Iteration counter width for the default operand width (counts WIDTH..0).
  localparam int unsigned CNT_W = $clog2(CALC_WIDTH + 1);

  // Same sizing rule for an arbitrary operand width.
  function automatic int unsigned calc_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/calc_seq_dp.sv
// Datapath for the ALU sequencer: operand/op registers, the shared
// (WIDTH+1)-bit adder/subtractor and the 2*WIDTH accumulator that serves as
// product register for MUL and remainder:quotient register for DIV.
// Divide stepping is only built when CALC_DIV_EN is defined.
module calc_seq_dp
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result_c,
  output logic             ovf_c
);

  localparam int unsigned AW = WIDTH + 1;

  calc_op_e             op_q, op_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 flag_q, flag_d;

  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [AW-1:0]        add_x;
  logic [AW-1:0]        add_y;
  logic [AW-1:0]        add_s;
  logic                 add_sub;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  // Operand steering for the single shared adder.
  always_comb begin
    add_x   = {1'b0, acc_lo};
    add_y   = {1'b0, b_q};
    add_sub = 1'b0;
    case (op_q)
      SUB: add_sub = 1'b1;
      MUL: add_x   = {1'b0, acc_hi};
`ifdef CALC_DIV_EN
      DIV: begin
        // Trial subtract of b from the remainder shifted left by one quotient bit.
        add_x   = {acc_hi, acc_lo[WIDTH-1]};
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Shared adder; bit WIDTH is the carry (add) or the borrow (subtract).
  assign add_s = add_x + (add_sub ? ~add_y : add_y) + AW'(add_sub);

  // Load operands on acceptance, advance one iteration per step.
  always_comb begin
    op_d   = op_q;
    b_d    = b_q;
    acc_d  = acc_q;
    flag_d = flag_q;
    if (load) begin
      op_d   = calc_op_e'(op_in);
      b_d    = b_in;
      acc_d  = {{WIDTH{1'b0}}, a_in};
      flag_d = 1'b0;
    end else if (step) begin
      case (op_q)
        ADD, SUB: begin
          acc_d  = {acc_hi, add_s[WIDTH-1:0]};
          flag_d = add_s[WIDTH];
        end
        MUL: begin
          // LSB-first shift-add: add b into the high half when the multiplier bit is set.
          if (acc_lo[0]) begin
            acc_d = {add_s, acc_lo[WIDTH-1:1]};
          end else begin
            acc_d = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
          end
        end
`ifdef CALC_DIV_EN
        DIV: begin
          // Restoring step: keep the difference and set the quotient bit unless it borrowed.
          if (add_s[WIDTH]) begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {add_s[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= ADD;
      b_q    <= '0;
      acc_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      flag_q <= flag_d;
    end
  end

  // Final result and overflow decode for the completed operation.
  always_comb begin
    ovf_c = 1'b0;
    case (op_q)
      ADD, SUB: ovf_c = flag_q;
      MUL:      ovf_c = |acc_hi;
      default:  ;
    endcase
  end

  assign result_c = acc_lo;

endmodule

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle ALU sequencer for the hex calculator: accepts an operation on a
// valid/ready request, runs it over the shared adder in calc_seq_dp and holds
// the result on a valid/ready response.
// Optional feature macro: CALC_DIV_EN (restoring divide; without it DIV
// returns result 0 with err set).
module calc_alu_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             busy
);

  localparam int unsigned CW = calc_cnt_w(WIDTH);

  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_pend_q, err_pend_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             accept;
  logic             finish;
  logic             rsp_hs;
  logic             req_is_err;
  logic             req_is_long;
  logic             dp_load;
  logic             dp_step;
  logic [WIDTH-1:0] dp_result;
  logic             dp_ovf;

  // Requests that complete without touching the adder.
`ifdef CALC_DIV_EN
  assign req_is_err = (calc_op_e'(req_op) == DIV) && (req_b == '0);
`else
  assign req_is_err = (calc_op_e'(req_op) == DIV);
`endif

  assign req_is_long = (calc_op_e'(req_op) == MUL) || (calc_op_e'(req_op) == DIV);

  assign accept = (state_q == IDLE) && req_valid && !clear;
  assign finish = (state_q == EXEC) && (cnt_q == '0) && !clear;
  assign rsp_hs = (state_q == DONE) && rsp_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_valid)      state_d = EXEC;
        EXEC:    if (cnt_q == '0)    state_d = DONE;
        DONE:    if (rsp_ready)      state_d = IDLE;
        default:                     state_d = IDLE;
      endcase
    end
  end

  // Sequencing controls and response register updates.
  // Error requests enter EXEC with a zero count so they report one edge later
  // without running any adder iterations.
  always_comb begin
    cnt_d      = cnt_q;
    err_pend_d = err_pend_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    err_d      = err_q;
    dp_load    = 1'b0;
    dp_step    = 1'b0;

    if (accept) begin
      dp_load    = 1'b1;
      err_pend_d = req_is_err;
      if (req_is_err) begin
        cnt_d = '0;
      end else if (req_is_long) begin
        cnt_d = CW'(WIDTH);
      end else begin
        cnt_d = CW'(1);
      end
    end

    if ((state_q == EXEC) && (cnt_q != '0)) begin
      dp_step = 1'b1;
      cnt_d   = cnt_q - CW'(1);
    end

    if (finish) begin
      if (err_pend_q) begin
`ifdef CALC_DIV_EN
        res_d = '1;
`else
        res_d = '0;
`endif
        ovf_d = 1'b0;
        err_d = 1'b1;
      end else begin
        res_d = dp_result;
        ovf_d = dp_ovf;
        err_d = 1'b0;
      end
    end

    // Flags only live while the response is held; the result value persists.
    if (rsp_hs || clear) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
  end

  // Counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  calc_seq_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (dp_load),
    .step     (dp_step),
    .op_in    (req_op),
    .a_in     (req_a),
    .b_in     (req_b),
    .result_c (dp_result),
    .ovf_c    (dp_ovf)
  );

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q == EXEC) || (state_q == DONE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = res_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Scoreboard bench for calc_alu_sequencer: directed cases plus randomized
// operations, expected responses from a plain-arithmetic reference model.
module tb_calc_alu_sequencer;

  localparam int W      = 32;
  localparam int BUDGET = 4 * (W + 8) + (1 << calc_pkg::CNT_W);

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_ovf;
  logic         rsp_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic rr_rand = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];

  calc_alu_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int acc);
    exp_t e;
    logic [2*W-1:0] w;
    e.acc = acc;
    e.err = 1'b0;
    e.ovf = 1'b0;
    e.lat = W + 1;
    e.res = '0;
    w     = '0;
    case (op)
      2'd0: begin
        w = (2*W)'(a) + (2*W)'(b);
        e.res = w[W-1:0];
        e.ovf = w[W];
        e.lat = 2;
      end
      2'd1: begin
        e.res = a - b;
        e.ovf = (a < b);
        e.lat = 2;
      end
      2'd2: begin
        w = (2*W)'(a) * (2*W)'(b);
        e.res = w[W-1:0];
        e.ovf = (w[2*W-1:W] != '0);
      end
      default: begin
`ifdef CALC_DIV_EN
        if (b == '0) begin
          e.res = '1;
          e.err = 1'b1;
          e.lat = 1;
        end else begin
          e.res = a / b;
        end
`else
        e.res = '0;
        e.err = 1'b1;
        e.lat = 1;
`endif
      end
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 255));
      3:       return W'($urandom_range(0, 65535));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one request from a negedge; the expected response is queued
  // before the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!req_ready && n < BUDGET) begin
      tick();
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    sb.push_back(model(op, a, b, cyc + 1));
    tick();
    req_valid = 1'b0;
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    req_op    = 2'($urandom_range(0, 3));
    chk("accept_busy", busy, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rsp_valid && n < BUDGET) begin
      tick();
      n++;
    end
    chk("rsp_valid_wait", rsp_valid, 1);
  endtask

  // Monitor: compare the held response against the scoreboard head.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_v = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(sb.size()), 1);
        end else begin
          chk("rsp_result", rsp_result, sb[0].res);
          chk("rsp_ovf", rsp_ovf, sb[0].ovf);
          chk("rsp_err", rsp_err, sb[0].err);
          chk("done_ready_busy", {req_ready, busy}, 2'b01);
          if (!prev_v) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          if (rsp_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_flags", {rsp_ovf, rsp_err}, 2'b00);
        chk("busy_vs_ready", busy, !req_ready);
      end
      prev_v = rsp_valid;
    end
  end

  initial begin
    logic [1:0]   d_op [7];
    logic [W-1:0] d_a  [7];
    logic [W-1:0] d_b  [7];
    int           n;

    d_op = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    d_a  = '{32'hFFFF_FFFF, 32'h10, 32'h20, 32'h0001_0000, 32'h1234, 32'h64, 32'h55};
    d_b  = '{32'h1, 32'h20, 32'h10, 32'h0001_0000, 32'h10, 32'h7, 32'h0};

    reset     = 1'b1;
    clear     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_state", {rsp_valid, rsp_ovf, rsp_err, busy, req_ready}, 5'b00001);
    chk("reset_result", rsp_result, 0);
    reset = 1'b0;
    tick();

    // Directed cases, consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
    end

    // Backpressure: MUL result held for 10 cycles, then released.
    n = 0;
    while (sb.size() != 0 && n < BUDGET) begin tick(); n++; end
    rsp_ready = 1'b0;
    issue(2'd2, 32'h0000_0003, 32'h0000_0005);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_result", rsp_result, 32'hF);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", {rsp_valid, req_ready}, 2'b01);
    issue(2'd0, 32'h0000_1000, 32'h0000_0234);

    // clear together with a request in IDLE: request is not taken.
    wait_valid();
    tick();
    req_valid = 1'b1;
    clear     = 1'b1;
    req_op    = 2'd0;
    tick();
    req_valid = 1'b0;
    clear     = 1'b0;
    chk("clear_blocks_req", busy, 0);

    // clear at EXEC cycle 5 of a MUL: no response ever appears.
    issue(2'd2, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (4) tick();
    clear = 1'b1;
    sb.delete();
    tick();
    clear = 1'b0;
    chk("clear_to_idle", {rsp_valid, req_ready}, 2'b01);
    repeat (W + 4) tick();
    chk("clear_no_rsp", {rsp_valid, busy}, 2'b00);

    // Asynchronous reset in the middle of EXEC.
    issue(2'd2, 32'h0000_0007, 32'h0000_0009);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_state", {rsp_valid, rsp_ovf, rsp_err, busy, req_ready}, 5'b00001);
    chk("async_reset_result", rsp_result, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Randomized operations with random consumer backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end

    // Drain.
    rr_rand   = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < BUDGET) begin tick(); n++; end
    chk("drain_empty", 64'(sb.size()), 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
